// File: rtl/apb_master.sv
// APB3 single-transfer master: host command in, APB SETUP/ACCESS sequencing, registered completion out.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  // Abort fires on the edge that would bring the wait count up to the limit.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
`endif

  assign cmd_ready = (state_q == S_IDLE);

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = 32'd0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= 32'd0;
      pwdata_q      <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= 8'd0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: inputs driven and outputs sampled on the falling edge.
// Build with APB_MASTER_TIMEOUT_EN defined to exercise the abort path (TIMEOUT_CYCLES=4).
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int n_checks = 0;
  int n_bad    = 0;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer starting at a falling edge in IDLE; returns at the falling edge of the rsp_valid cycle.
  // hold=1 keeps cmd_valid high throughout so the next call is accepted in the rsp_valid cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input logic slverr,
                      input logic hold);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    check("cmd_ready_idle", cmd_ready, 1);
    check("psel_idle", PSELx, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_write = ~wr;
      cmd_addr  = ~addr;
      cmd_wdata = ~wdata;
    end
    check("setup_psel", PSELx, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_cmd_ready", cmd_ready, 0);
    // PREADY/PSLVERR asserted during SETUP must be ignored
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hBAD0_BAD0;
    @(posedge PCLK);
    for (int i = 0; i <= waits; i++) begin
      @(negedge PCLK);
      check("access_penable", PENABLE, 1);
      check("access_psel", PSELx, 1);
      check("access_paddr", PADDR, addr);
      check("access_pwdata", PWDATA, wdata);
      check("access_rsp_valid", rsp_valid, 0);
      check("access_cmd_ready", cmd_ready, 0);
      if (i < waits) begin
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'h0BAD_0000 | i;
      end else begin
        PREADY  = 1'b1;
        PSLVERR = slverr;
        PRDATA  = rdata;
      end
      @(posedge PCLK);
    end
    @(negedge PCLK);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h7777_7777;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, slverr);
    check("rsp_timeout", rsp_timeout, 0);
    check("rsp_rdata", rsp_rdata, wr ? 32'd0 : rdata);
    check("done_psel", PSELx, 0);
    check("done_penable", PENABLE, 0);
    check("done_paddr_held", PADDR, addr);
    check("done_cmd_ready", cmd_ready, 1);
  endtask

  task automatic idle_tail(input logic [31:0] exp_rdata, input logic exp_err, input logic [31:0] exp_addr);
    @(negedge PCLK);
    check("tail_rsp_valid", rsp_valid, 0);
    check("tail_rsp_rdata", rsp_rdata, exp_rdata);
    check("tail_rsp_err", rsp_err, exp_err);
    check("tail_psel", PSELx, 0);
    check("tail_paddr", PADDR, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'd0, 1'b0, 1'b0);
    idle_tail(32'd0, 1'b0, 32'h10);

    // Read with three wait states (also the PREADY-wins boundary when the timeout is built in)
    xfer(1'b0, 32'h13, 32'd0, 3, 32'hCAFE_0001, 1'b0, 1'b0);
    idle_tail(32'hCAFE_0001, 1'b0, 32'h13);

    // Slave error on a read
    xfer(1'b0, 32'h1000, 32'd0, 0, 32'h1234_5678, 1'b1, 1'b0);
    idle_tail(32'h1234_5678, 1'b1, 32'h1000);

    // Back-to-back: second request accepted in the rsp_valid cycle
    xfer(1'b0, 32'h20, 32'd0, 1, 32'hA5A5_0001, 1'b0, 1'b1);
    xfer(1'b1, 32'h24, 32'h0000_55AA, 0, 32'd0, 1'b0, 1'b0);
    idle_tail(32'd0, 1'b0, 32'h24);

    // PREADY stuck low
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    @(posedge PCLK);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("to_access_penable", PENABLE, 1);
      check("to_access_rsp_valid", rsp_valid, 0);
      @(posedge PCLK);
    end
    @(negedge PCLK);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", PSELx, 0);
    @(negedge PCLK);
    check("to_tail_rsp_valid", rsp_valid, 0);
    check("to_tail_rsp_timeout", rsp_timeout, 1);

    // Get into ACCESS again for the reset test
    cmd_valid = 1'b1;
    cmd_addr  = 32'h44;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
`else
    begin
      int seen_rsp = 0;
      int seen_idle = 0;
      for (int i = 0; i < 120; i++) begin
        @(negedge PCLK);
        if (rsp_valid) seen_rsp++;
        if (!PENABLE) seen_idle++;
      end
      check("stuck_no_rsp", seen_rsp, 0);
      check("stuck_no_idle", seen_idle, 0);
      check("stuck_penable", PENABLE, 1);
      check("stuck_rsp_timeout", rsp_timeout, 0);
    end
`endif

    // Asynchronous reset in ACCESS
    check("pre_rst_penable", PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("arst_psel", PSELx, 0);
    check("arst_penable", PENABLE, 0);
    check("arst_paddr", PADDR, 0);
    check("arst_rsp_timeout", rsp_timeout, 0);
    @(negedge PCLK);
    check("arst_rsp_valid", rsp_valid, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_psel", PSELx, 0);

    // Normal operation after reset
    xfer(1'b0, 32'h50, 32'd0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
    idle_tail(32'h0BAD_F00D, 1'b0, 32'h50);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
